// File: rtl/fpu_tb_pkg.sv
// Shared encodings for the FPU transaction sequencer: op codes, rounding modes,
// flag bit positions and the sequencer FSM state type.
package fpu_tb_pkg;

  localparam int FLAGS_W = 14;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;

  localparam logic [1:0] RM_NEAREST = 2'd0;
  localparam logic [1:0] RM_ZERO    = 2'd1;
  localparam logic [1:0] RM_POS_INF = 2'd2;
  localparam logic [1:0] RM_NEG_INF = 2'd3;

  // Bit positions within the 14-bit flag word, MSB first
  localparam int FLG_INF         = 13;
  localparam int FLG_SNAN        = 12;
  localparam int FLG_QNAN        = 11;
  localparam int FLG_INE         = 10;
  localparam int FLG_OVERFLOW    = 9;
  localparam int FLG_UNDERFLOW   = 8;
  localparam int FLG_ZERO        = 7;
  localparam int FLG_DIV_BY_ZERO = 6;
  localparam int FLG_UNORDERED   = 5;
  localparam int FLG_ALTB        = 4;
  localparam int FLG_BLTA        = 3;
  localparam int FLG_AEQB        = 2;
  localparam int FLG_INF_IN      = 1;
  localparam int FLG_ZERO_A      = 0;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } seq_state_e;

endpackage

// File: rtl/fpu_rsp_fifo.sv
// Response FIFO: power-of-two ring buffer with the head word presented
// combinationally and an occupancy count one bit wider than the pointers.
module fpu_rsp_fifo
  import fpu_tb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4 + 32 + FLAGS_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_rd;
  logic             full;

  always_comb begin
    do_rd    = rd_en && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_en, do_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem[rd_ptr_q];
  assign count   = count_q;
  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW + 1)'(DEPTH));

  // Upstream credit accounting guarantees a free slot for every capture
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(wr_en && full));

endmodule

// File: rtl/fpu_txn_sequencer.sv
// Issues requests to a fixed-latency FPU, tracks them with a tag pipe and returns
// results in order through a credit-protected response FIFO, with a drain handshake.
module fpu_txn_sequencer
  import fpu_tb_pkg::*;
#(
  parameter int LATENCY = 5,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [2:0]         req_op,
  input  logic [1:0]         req_rmode,
  input  logic [31:0]        req_opa,
  input  logic [31:0]        req_opb,
  input  logic [3:0]         req_tag,
  output logic [2:0]         fpu_op,
  output logic [1:0]         rmode,
  output logic [31:0]        opa,
  output logic [31:0]        opb,
  input  logic [31:0]        fpu_out,
  input  logic [FLAGS_W-1:0] fpu_flags,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [3:0]         rsp_tag,
  output logic [31:0]        rsp_out,
  output logic [FLAGS_W-1:0] rsp_flags,
  input  logic               drain_req,
  output logic               drain_done,
  output logic [15:0]        issued_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int RW = 4 + 32 + FLAGS_W;

  seq_state_e         state_q, state_d;
  logic               started_q, started_d;
  logic [2:0]         fpu_op_q, fpu_op_d;
  logic [1:0]         rmode_q, rmode_d;
  logic [31:0]        opa_q, opa_d;
  logic [31:0]        opb_q, opb_d;
  logic [LATENCY-1:0] pipe_vld_q, pipe_vld_d;
  logic [3:0]         pipe_tag_q [LATENCY];
  logic [3:0]         pipe_tag_d [LATENCY];
  logic [CW-1:0]      inflight_q, inflight_d;
  logic [15:0]        issued_q, issued_d;

  logic [CW-1:0]      fifo_count;
  logic               fifo_empty;
  logic [RW-1:0]      fifo_head;
  logic [CW:0]        used;
  logic               accept, capture, pop;

  // started_q holds off acceptance until one full edge after reset release
  assign used      = {1'b0, inflight_q} + {1'b0, fifo_count};
  assign req_ready = started_q && (state_q == RUN) && (used < (CW + 1)'(DEPTH));
  assign accept    = req_valid && req_ready;
  assign capture   = pipe_vld_q[LATENCY-1];
  assign rsp_valid = !fifo_empty;
  assign pop       = rsp_valid && rsp_ready;

  assign {rsp_tag, rsp_out, rsp_flags} = rsp_valid ? fifo_head : '0;
  assign fpu_op     = fpu_op_q;
  assign rmode      = rmode_q;
  assign opa        = opa_q;
  assign opb        = opb_q;
  assign issued_cnt = issued_q;

  always_comb begin
    started_d  = 1'b1;
    fpu_op_d   = fpu_op_q;
    rmode_d    = rmode_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    pipe_vld_d = '0;
    pipe_tag_d = '{default: '0};
    if (accept) begin
      fpu_op_d = req_op;
      rmode_d  = req_rmode;
      opa_d    = req_opa;
      opb_d    = req_opb;
    end
    pipe_vld_d[0] = accept;
    pipe_tag_d[0] = accept ? req_tag : 4'd0;
    for (int i = 1; i < LATENCY; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_tag_d[i] = pipe_tag_q[i-1];
    end
    inflight_d = inflight_q + CW'(accept) - CW'(capture);
    issued_d   = issued_q + 16'(accept);
  end

  always_comb begin
    state_d    = state_q;
    drain_done = 1'b0;
    unique case (state_q)
      RUN:     if (drain_req) state_d = DRAIN;
      DRAIN:   if (inflight_q == '0 && fifo_count == '0) state_d = DONE;
      DONE: begin
        drain_done = 1'b1;
        state_d    = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      started_q  <= 1'b0;
      fpu_op_q   <= '0;
      rmode_q    <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      pipe_vld_q <= '0;
      pipe_tag_q <= '{default: '0};
      inflight_q <= '0;
      issued_q   <= '0;
    end else begin
      state_q    <= state_d;
      started_q  <= started_d;
      fpu_op_q   <= fpu_op_d;
      rmode_q    <= rmode_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      pipe_vld_q <= pipe_vld_d;
      pipe_tag_q <= pipe_tag_d;
      inflight_q <= inflight_d;
      issued_q   <= issued_d;
    end
  end

  fpu_rsp_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(RW)
  ) u_rsp_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (capture),
    .wr_data({pipe_tag_q[LATENCY-1], fpu_out, fpu_flags}),
    .rd_en  (pop),
    .rd_data(fifo_head),
    .count  (fifo_count),
    .empty  (fifo_empty)
  );

endmodule

// File: doc/fpu_txn_sequencer.md
FPU_TXN_SEQUENCER -- requirements
Module: fpu_txn_sequencer

Interface
REQ-001 SHALL have parameter LATENCY, default 5: edges from the edge that loads the FPU drive registers to the edge at which the FPU result is sampled (range 1..15).
REQ-002 SHALL have parameter DEPTH, default 4: response FIFO entries, a power of 2 in the range 2..16.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 Port clk, in, 1: rising-edge clock.
REQ-005 Port rst_n, in, 1: asynchronous active-low reset.
REQ-006 Ports req_valid in 1, req_ready out 1, req_op in 3, req_rmode in 2, req_opa in 32, req_opb in 32, req_tag in 4: request channel.
REQ-007 Ports fpu_op out 3, rmode out 2, opa out 32, opb out 32: drive to FPU input bundle.
REQ-008 Port fpu_out, in, 32: FPU result word.
REQ-009 Port fpu_flags, in, 14: {inf,snan,qnan,ine,overflow,underflow,zero,div_by_zero,unordered,altb,blta,aeqb,inf_in,zero_a}, MSB first.
REQ-010 Ports rsp_valid out 1, rsp_ready in 1, rsp_tag out 4, rsp_out out 32, rsp_flags out 14: response channel.
REQ-011 Ports drain_req in 1 and drain_done out 1: drain control; drain_done is a one-cycle pulse.

Function
REQ-012 Accept on an edge where req_valid and req_ready are both high; at that edge fpu_op, rmode, opa and opb load from req_*.
REQ-013 Drive registers SHALL hold their value on cycles with no acceptance.
REQ-014 Tag pipe: a LATENCY-deep shift of {valid,tag} loaded at acceptance; a bubble (valid=0) is inserted otherwise.
REQ-015 When the pipe tail is valid at edge E0+LATENCY, {tag,fpu_out,fpu_flags} SHALL be written to the FIFO; rsp_valid SHALL be high from that edge onward.
REQ-016 Credit: req_ready=1 only when state==RUN and (inflight + fifo_count) < DEPTH, using registered counts.
REQ-017 A pop in the same cycle SHALL NOT be credited to req_ready in that cycle.
REQ-018 Consequence of the credit rule: FIFO overflow is impossible; a capture while the FIFO is full is an assertion failure.
REQ-019 Response: FIFO head is presented on rsp_*; pop on rsp_valid&&rsp_ready; order SHALL equal issue order.
REQ-020 Simultaneous capture and pop: both take effect, fifo_count is unchanged; an empty FIFO with a simultaneous capture stays non-empty.
REQ-021 FIFO pointers wrap modulo DEPTH; fifo_count width is clog2(DEPTH)+1.
REQ-022 FSM states: RUN, DRAIN, DONE.
REQ-023 RUN -> DRAIN on drain_req=1.
REQ-024 DRAIN: req_ready=0; transition to DONE when inflight==0 and fifo_count==0.
REQ-025 DONE: drain_done=1 for one cycle, then -> RUN; drain_req asserted in DONE is ignored.
REQ-026 drain_req asserted while already in DRAIN is a no-op.
REQ-027 Counter issued_cnt (16-bit, wraps) increments per acceptance; it is exposed for bench debug only.

Reset
REQ-028 With rst_n=0, all outputs SHALL immediately be 0: req_ready, fpu_op, rmode, opa, opb, rsp_valid, rsp_tag, rsp_out, rsp_flags, drain_done.
REQ-029 With rst_n=0, the tag pipe, FIFO pointers and counts, and issued_cnt SHALL be cleared, and the FSM SHALL enter RUN.
REQ-030 Reset mid-operation SHALL discard all in-flight and buffered results; no response may appear for pre-reset requests.
REQ-031 req_ready SHALL first be 1 in the cycle after the edge following rst_n deassertion.

Structure
REQ-032 Shared package fpu_tb_pkg SHALL hold: the FPU op encodings (ADD=0, SUB=1, MUL=2, DIV=3), rmode encodings, flag bit indices, the FSM state enum, and FLAGS_W=14.
REQ-033 FIFO SHALL be one sub-module, fpu_rsp_fifo (parameters DEPTH and WIDTH=50); everything else is inline.

Verification
REQ-034 ADD, rmode 0, opa 0x3F800000, opb 0x40000000, tag 3 -> rsp_out 0x40400000, tag 3, all flags 0, rsp_valid 5 edges after acceptance.
REQ-035 DIV, opa 0x3F800000, opb 0x00000000 -> rsp_out 0x7F800000, div_by_zero=1, inf=1.
REQ-036 rsp_ready=0, 6 back-to-back requests -> exactly 4 accepted, req_ready low; pop one -> req_ready high the following cycle.
REQ-037 8 requests with tags 0..7 and random rsp_ready -> responses returned in tag order 0..7 with no loss or duplication.
REQ-038 rst_n pulsed low with 3 in flight and 2 buffered -> rsp_valid=0 immediately; no stale response after release.
REQ-039 drain_req with 2 in flight -> req_ready=0 until drained; drain_done pulses once after the last pop; back to RUN.
